vga_ram_arbiter: RTL and testbench
==================================

VGA_RAM_ARBITER -- requirements
Module: vga_ram_arbiter

Interface
REQ-001 Parameter AddressWidth, default 14, SHALL set the RAM address width.
REQ-002 Parameter DataWidth, default 8, SHALL set the pixel word width.
REQ-003 Parameter FifoDepth, default 4 (power of 2, >=2), SHALL set the write-buffer entry count.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 vid_req  in  1  video read request, one pixel per asserted cycle.
REQ-007 vid_addr  in  AddressWidth  video read address.
REQ-008 vid_valid  out  1  vid_data valid for the request issued the previous cycle.
REQ-009 vid_data  out  DataWidth  pixel read from RAM.
REQ-010 wr_valid  in  1  host write request.
REQ-011 wr_ready  out  1  write buffer can accept an entry.
REQ-012 wr_addr  in  AddressWidth  host write address.
REQ-013 wr_data  in  DataWidth  host write data.
REQ-014 ram_rw  out  1  RAM read/write select: 1 = read, 0 = write.
REQ-015 ram_addr  out  AddressWidth  RAM address.
REQ-016 ram_wdata  out  DataWidth  RAM write data.
REQ-017 ram_rdata  in  DataWidth  RAM registered read data (1-cycle latency).
REQ-018 fifo_level  out  log2(FifoDepth)+1  current buffered-write count.
REQ-019 wr_starved  out  1  sticky starvation flag.

Function
REQ-020 The write buffer SHALL be a FifoDepth-entry FIFO of {addr, data}; push when wr_valid && wr_ready; wr_ready = (fifo_level != FifoDepth), registered state only (no combinational path from wr_valid).
REQ-021 The grant SHALL be combinational per cycle, with video as fixed highest priority:
- vid_req=1 -> ram_rw=1, ram_addr=vid_addr.
- vid_req=0 and FIFO non-empty -> ram_rw=0, ram_addr/ram_wdata = FIFO head; head popped at that clock edge.
- otherwise -> ram_rw=1, ram_addr=0 (idle read, harmless).
REQ-022 vid_valid SHALL be vid_req registered one cycle; vid_data SHALL equal ram_rdata (pass-through); request in cycle N -> data valid in cycle N+1.
REQ-023 Simultaneous push and pop SHALL be allowed in one cycle; fifo_level unchanged.
REQ-024 Full FIFO: wr_ready=0 even if a pop occurs that cycle; wr_ready rises the cycle after the pop.
REQ-025 Empty FIFO: an entry pushed in cycle N SHALL be writable to RAM no earlier than cycle N+1 (no bypass).
REQ-026 Pointers SHALL wrap modulo FifoDepth; FIFO order SHALL be preserved across wrap.
REQ-027 No read/write forwarding: a video read of an address pending in the FIFO SHALL return the current RAM content.
REQ-028 stall_cnt (8-bit, internal) SHALL increment each cycle FIFO is non-empty and vid_req=1, clear on any RAM write cycle, and saturate at 255.
REQ-029 wr_starved SHALL set when stall_cnt reaches 255 and stay set until reset.
REQ-030 ram_rw SHALL never be 0 while vid_req=1.

Reset
REQ-031 On rstn=0 (asynchronous): FIFO pointers=0, fifo_level=0, wr_ready=1, vid_valid=0, stall_cnt=0, wr_starved=0; with vid_req=0, ram_rw=1.
REQ-032 Reset mid-operation SHALL discard all buffered writes; none reach RAM after rstn rises.
REQ-033 Operation SHALL resume on the first rising clk edge with rstn=1.

Verification
REQ-034 Idle write: vid_req=0, push (addr 0x0010, data 0xA5) -> cycle+1 ram_rw=0, ram_addr=0x0010, ram_wdata=0xA5; fifo_level 1->0.
REQ-035 Priority: vid_req=1 continuously, push 4 writes -> fifo_level=4, wr_ready=0, ram_rw stays 1; drop vid_req -> 4 writes drain in push order, one per cycle.
REQ-036 Read latency: RAM preloaded, vid_req=1 with addr 0x0000..0x0003 over 4 cycles -> vid_valid=1 cycles 2..5 with matching preload data.
REQ-037 Starvation: FIFO non-empty, vid_req=1 for 300 cycles -> wr_starved=1 from cycle 255, stays set after writes drain.
REQ-038 Reset mid-drain: 3 entries buffered, rstn pulsed low -> fifo_level=0, wr_ready=1, no RAM write afterward.
REQ-039 Wrap: 10 writes with random vid_req gaps -> RAM contents match all 10 writes in order.

Source files
------------

// File: rtl/vga_ram_arbiter.sv
// Single-port RAM arbiter: video reads take fixed priority over host writes,
// which wait in a small FIFO and drain into the RAM whenever video is idle.
module vga_ram_arbiter #(
    parameter int unsigned AddressWidth = 14,
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned FifoDepth    = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           vid_req,
    input  logic [AddressWidth-1:0]        vid_addr,
    output logic                           vid_valid,
    output logic [DataWidth-1:0]           vid_data,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [AddressWidth-1:0]        wr_addr,
    input  logic [DataWidth-1:0]           wr_data,
    output logic                           ram_rw,
    output logic [AddressWidth-1:0]        ram_addr,
    output logic [DataWidth-1:0]           ram_wdata,
    input  logic [DataWidth-1:0]           ram_rdata,
    output logic [$clog2(FifoDepth):0]     fifo_level,
    output logic                           wr_starved
);

    localparam int unsigned PtrWidth   = $clog2(FifoDepth);
    localparam int unsigned LevelWidth = PtrWidth + 1;
    localparam logic [LevelWidth-1:0] FullLevel = LevelWidth'(FifoDepth);
    localparam logic [7:0] StallMax = 8'hFF;

    logic [AddressWidth-1:0] addr_mem [FifoDepth];
    logic [DataWidth-1:0]    data_mem [FifoDepth];
    logic [PtrWidth-1:0]     wr_ptr;
    logic [PtrWidth-1:0]     rd_ptr;
    logic [7:0]              stall_cnt;
    logic [7:0]              stall_next;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;

    assign fifo_empty = (fifo_level == '0);
    assign wr_ready   = (fifo_level != FullLevel);
    assign push       = wr_valid && wr_ready;
    assign pop        = !vid_req && !fifo_empty;
    assign vid_data   = ram_rdata;

    // Grant: video read, else drain FIFO head, else a harmless idle read of address 0.
    always_comb begin
        ram_rw    = 1'b1;
        ram_addr  = '0;
        ram_wdata = '0;
        if (vid_req) begin
            ram_addr = vid_addr;
        end else if (!fifo_empty) begin
            ram_rw    = 1'b0;
            ram_addr  = addr_mem[rd_ptr];
            ram_wdata = data_mem[rd_ptr];
        end
    end

    // Counts cycles a buffered write is held off by video; any write clears it.
    always_comb begin
        stall_next = stall_cnt;
        if (pop) begin
            stall_next = '0;
        end else if (vid_req && !fifo_empty && (stall_cnt != StallMax)) begin
            stall_next = stall_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            vid_valid  <= 1'b0;
            stall_cnt  <= '0;
            wr_starved <= 1'b0;
        end else begin
            vid_valid  <= vid_req;
            stall_cnt  <= stall_next;
            wr_starved <= wr_starved | (stall_next == StallMax);
            if (push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LevelWidth'(1);
                2'b01:   fifo_level <= fifo_level - LevelWidth'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= wr_addr;
            data_mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Testbench for vga_ram_arbiter: behavioural RAM plus a queue-based reference
// model compared every cycle, with directed scenarios and literal checks.
module tb_vga_ram_arbiter;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk;
    logic          rstn;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [2:0]    fifo_level;
    logic          wr_starved;

    int n_cmp = 0;
    int n_fail = 0;
    int n_wr = 0;
    bit started = 1'b0;
    bit rand_vid = 1'b0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    vga_ram_arbiter dut (
        .clk(clk), .rstn(rstn),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_valid(vid_valid), .vid_data(vid_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .fifo_level(fifo_level), .wr_starved(wr_starved)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM with registered read data.
    always @(posedge clk) begin
        if (ram_rw == 1'b0) begin
            mem[ram_addr] <= ram_wdata;
            n_wr <= n_wr + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as a queue, pixel expected from RAM at request time.
    wr_t           q[$];
    bit            exp_vv = 1'b0;
    logic [DW-1:0] exp_pix = '0;
    int            stall = 0;
    bit            starved = 1'b0;

    always @(negedge clk) begin : model
        int sz;
        bit do_pop;
        bit do_push;
        if (started) begin
            if (!rstn) begin
                q.delete();
                exp_vv = 1'b0;
                stall = 0;
                starved = 1'b0;
                chk("rst_level", 32'(fifo_level), 32'd0);
                chk("rst_wr_ready", 32'(wr_ready), 32'd1);
                chk("rst_vid_valid", 32'(vid_valid), 32'd0);
                chk("rst_starved", 32'(wr_starved), 32'd0);
            end else begin
                sz = q.size();
                chk("vid_valid", 32'(vid_valid), 32'(exp_vv));
                if (exp_vv) chk("vid_data", 32'(vid_data), 32'(exp_pix));
                chk("fifo_level", 32'(fifo_level), 32'(sz));
                chk("wr_ready", 32'(wr_ready), 32'(sz != DEPTH));
                chk("wr_starved", 32'(wr_starved), 32'(starved));
                if (vid_req) begin
                    chk("grant_rd_rw", 32'(ram_rw), 32'd1);
                    chk("grant_rd_addr", 32'(ram_addr), 32'(vid_addr));
                end else if (sz > 0) begin
                    chk("grant_wr_rw", 32'(ram_rw), 32'd0);
                    chk("grant_wr_addr", 32'(ram_addr), 32'(q[0].a));
                    chk("grant_wr_data", 32'(ram_wdata), 32'(q[0].d));
                end else begin
                    chk("idle_rw", 32'(ram_rw), 32'd1);
                    chk("idle_addr", 32'(ram_addr), 32'd0);
                end
                exp_vv = vid_req;
                if (vid_req) exp_pix = mem[vid_addr];
                do_pop = !vid_req && (sz > 0);
                do_push = wr_valid && (sz != DEPTH);
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back('{a: wr_addr, d: wr_data});
                if (do_pop) stall = 0;
                else if (vid_req && sz > 0 && stall < 255) stall++;
                if (stall == 255) starved = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_vid) vid_req = 1'($urandom_range(0, 1));
    endtask

    task automatic look();
        #2;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr = a;
        wr_data = d;
        wr_valid = 1'b1;
        for (int k = 0; k < 200 && !wr_ready; k++) step();
        if (!wr_ready) chk("push_timeout", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic drain();
        vid_req = 1'b0;
        for (int k = 0; k < 50 && fifo_level != 0; k++) step();
        chk("drain_done", 32'(fifo_level), 32'd0);
    endtask

    logic [DW-1:0] pre [4];
    logic [DW-1:0] wd [10];
    int w0;

    initial begin
        rstn = 1'b1;
        vid_req = 1'b0;
        vid_addr = '0;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33; pre[3] = 8'h44;
        #1 rstn = 1'b0;
        started = 1'b1;
        step();
        look();
        chk("reset_ram_rw", 32'(ram_rw), 32'd1);
        chk("reset_level", 32'(fifo_level), 32'd0);
        step();
        rstn = 1'b1;

        // Idle write reaches RAM the cycle after the push.
        push(14'h0010, 8'hA5);
        look();
        chk("idle_wr_rw", 32'(ram_rw), 32'd0);
        chk("idle_wr_addr", 32'(ram_addr), 32'h0010);
        chk("idle_wr_data", 32'(ram_wdata), 32'hA5);
        chk("idle_wr_level1", 32'(fifo_level), 32'd1);
        step();
        look();
        chk("idle_wr_level0", 32'(fifo_level), 32'd0);
        chk("idle_wr_mem", 32'(mem[14'h0010]), 32'hA5);

        // Video holds off writes until the FIFO is full, then they drain in order.
        vid_req = 1'b1;
        vid_addr = 14'h0200;
        for (int i = 0; i < 4; i++) push(14'(14'h0020 + i), 8'(8'hB0 + i));
        look();
        chk("prio_level", 32'(fifo_level), 32'd4);
        chk("prio_wr_ready", 32'(wr_ready), 32'd0);
        chk("prio_rw", 32'(ram_rw), 32'd1);
        vid_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("prio_drain_addr", 32'(ram_addr), 32'(14'h0020 + i));
            chk("prio_drain_data", 32'(ram_wdata), 32'(8'hB0 + i));
            chk("prio_ready_after_pop", 32'(wr_ready), 32'(i != 0));
            step();
        end
        look();
        chk("prio_empty", 32'(fifo_level), 32'd0);

        // Preload then read back with one-cycle latency.
        for (int i = 0; i < 4; i++) push(14'(i), pre[i]);
        drain();
        for (int i = 0; i < 5; i++) begin
            vid_req = (i < 4);
            vid_addr = 14'(i % 4);
            look();
            if (i > 0) begin
                chk("rd_lat_valid", 32'(vid_valid), 32'd1);
                chk("rd_lat_data", 32'(vid_data), 32'(pre[i-1]));
            end
            step();
        end
        look();
        chk("rd_lat_valid_off", 32'(vid_valid), 32'd0);

        // Ten writes with random video gaps; pointers wrap.
        rand_vid = 1'b1;
        vid_addr = 14'h0300;
        for (int i = 0; i < 10; i++) begin
            wd[i] = 8'(i * 37 + 3);
            push(14'(14'h0100 + i), wd[i]);
        end
        rand_vid = 1'b0;
        drain();
        for (int i = 0; i < 10; i++) chk("wrap_mem", 32'(mem[14'h0100 + i]), 32'(wd[i]));

        // Starvation flag sets after 255 stalled cycles and is sticky.
        vid_req = 1'b1;
        vid_addr = 14'h3000;
        push(14'h0300, 8'hC3);
        for (int k = 0; k < 254; k++) step();
        look();
        chk("starved_254", 32'(wr_starved), 32'd0);
        step();
        look();
        chk("starved_255", 32'(wr_starved), 32'd1);
        for (int k = 0; k < 45; k++) step();
        drain();
        look();
        chk("starved_sticky", 32'(wr_starved), 32'd1);
        chk("starved_mem", 32'(mem[14'h0300]), 32'hC3);

        // Reset mid-drain discards buffered writes.
        vid_req = 1'b1;
        vid_addr = 14'h0000;
        for (int i = 0; i < 3; i++) push(14'(14'h0400 + i), 8'(8'hD0 + i));
        vid_req = 1'b0;
        step();
        look();
        chk("mid_drain_level", 32'(fifo_level), 32'd2);
        rstn = 1'b0;
        #1;
        chk("rst_mid_level", 32'(fifo_level), 32'd0);
        chk("rst_mid_ready", 32'(wr_ready), 32'd1);
        chk("rst_mid_starved", 32'(wr_starved), 32'd0);
        w0 = n_wr;
        step();
        step();
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) step();
        look();
        chk("rst_no_writes", 32'(n_wr), 32'(w0));
        chk("rst_level_after", 32'(fifo_level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
